// File: rtl/dvb_s2x_bbh_pkg.sv
// DVB-S2X BBHEADER parser shared definitions: FSM state enum, packed header
// layout, header length, CRC-8 polynomial and a byte-serial CRC-8 step.
package dvb_s2x_bbh_pkg;

  localparam int unsigned cBBH_LEN   = 10;
  localparam logic [7:0]  cCRC8_POLY = 8'hD5;
  localparam int unsigned HDR_CNT_W  = 4;
  localparam int unsigned DFL_CNT_W  = 13;
  localparam int unsigned TAG_W      = 9;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DATA = 2'd1,
    ST_PAD  = 2'd2,
    ST_DROP = 2'd3
  } bbh_state_e;

  // Header bytes in arrival order, big-endian fields.
  typedef struct packed {
    logic [15:0] matype;
    logic [15:0] upl;
    logic [15:0] dfl;
    logic [7:0]  sync;
    logic [15:0] syncd;
    logic [7:0]  crc;
  } bbh_hdr_t;

  // One byte of CRC-8, MSB first.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ data[i];
      c  = {c[6:0], 1'b0} ^ (fb ? cCRC8_POLY : 8'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/dvb_s2x_bbh_crc8.sv
// Byte-serial CRC-8 accumulator over the BBHEADER.
// Ports: clk, rst (sync, active-high), clr (restart at 0), en (fold data in),
//        data (byte), crc (running remainder).
module dvb_s2x_bbh_crc8
  import dvb_s2x_bbh_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  always_ff @(posedge clk) begin
    if (rst || clr) crc <= 8'h00;
    else if (en)    crc <= crc8_step(crc, data);
  end

endmodule

// File: rtl/dvb_s2x_bbh_parser.sv
// DVB-S2X BBFRAME header parser: strips the 10-byte BBHEADER, publishes its
// fields, forwards DFL/8 data-field bytes and consumes padding up to tlast.
// Ports: iclk/ireset (sync, active-high); s_axis_* byte input from decoder;
//        m_axis_* data-field output; ohdr_valid + omatype/oupl/odfl/osync/
//        osyncd/omode_hem header fields; ocrc_err/odfl_err/otrunc pulses.
// Build option: DVB_S2X_BBH_CRC_CHECK_EN enables header CRC-8 checking and
//        HEM detection; without it every header is accepted.
module dvb_s2x_bbh_parser
  import dvb_s2x_bbh_pkg::*;
(
  input  logic              iclk,
  input  logic              ireset,
  input  logic              s_axis_tvalid,
  input  logic [7:0]        s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic [TAG_W-1:0]  s_axis_tuser,
  output logic              s_axis_tready,
  input  logic              m_axis_tready,
  output logic              m_axis_tvalid,
  output logic [7:0]        m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [TAG_W-1:0]  m_axis_tuser,
  output logic              ohdr_valid,
  output logic [15:0]       omatype,
  output logic [15:0]       oupl,
  output logic [15:0]       odfl,
  output logic [7:0]        osync,
  output logic [15:0]       osyncd,
  output logic              omode_hem,
  output logic              ocrc_err,
  output logic              odfl_err,
  output logic              otrunc
);

  bbh_state_e           state, state_nxt;
  logic [HDR_CNT_W-1:0] hdr_cnt;
  logic [71:0]          hdr_buf;
  logic [DFL_CNT_W-1:0] dfl_rem;
  logic [TAG_W-1:0]     frame_tag;
  bbh_hdr_t             hdr_c;
  logic                 s_accept, hdr_last_byte;
  logic                 hdr_ok, crc_bad, crc_fail, dfl_bad, trunc_set;
  logic                 data_load, data_last;

  // Output register may only be refilled when empty or draining this cycle.
  assign s_axis_tready = !ireset && ((state != ST_DATA) || !m_axis_tvalid || m_axis_tready);
  assign s_accept      = s_axis_tvalid && s_axis_tready;
  assign hdr_c         = bbh_hdr_t'({hdr_buf, s_axis_tdata});
  assign hdr_last_byte = (hdr_cnt == HDR_CNT_W'(cBBH_LEN - 1));

`ifdef DVB_S2X_BBH_CRC_CHECK_EN
  logic [7:0] crc_q, residue;
  logic       crc_clr, crc_en, hem_c;

  // CRC covers bytes 0..8; restart after every header end or abort.
  assign crc_en  = s_accept && (state == ST_HDR) && !hdr_last_byte;
  assign crc_clr = (state != ST_HDR) || (s_accept && (hdr_last_byte || s_axis_tlast));

  dvb_s2x_bbh_crc8 u_crc8 (
    .clk  (iclk),
    .rst  (ireset),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (s_axis_tdata),
    .crc  (crc_q)
  );

  assign residue = crc_q ^ hdr_c.crc;
  assign crc_bad = (residue[7:1] != 7'd0);
  assign hem_c   = (residue == 8'h01);
`else
  logic unused_crc;
  assign crc_bad    = 1'b0;
  assign unused_crc = ^{hdr_c.crc, crc_fail};
`endif

  // Next-state and per-byte control decode.
  always_comb begin
    state_nxt = state;
    hdr_ok    = 1'b0;
    crc_fail  = 1'b0;
    dfl_bad   = 1'b0;
    trunc_set = 1'b0;
    data_load = 1'b0;
    data_last = 1'b0;
    case (state)
      ST_HDR: begin
        if (s_accept) begin
          if (hdr_last_byte) begin
            if (crc_bad) begin
              crc_fail  = 1'b1;
              state_nxt = s_axis_tlast ? ST_HDR : ST_DROP;
            end else if (hdr_c.dfl[2:0] != 3'd0) begin
              dfl_bad   = 1'b1;
              state_nxt = s_axis_tlast ? ST_HDR : ST_DROP;
            end else begin
              hdr_ok = 1'b1;
              // A frame ending right after its header cannot carry a data field.
              if (s_axis_tlast) begin
                state_nxt = ST_HDR;
                trunc_set = (hdr_c.dfl[15:3] != 13'd0);
              end else if (hdr_c.dfl[15:3] == 13'd0) begin
                state_nxt = ST_PAD;
              end else begin
                state_nxt = ST_DATA;
              end
            end
          end else if (s_axis_tlast) begin
            trunc_set = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_accept) begin
          data_load = 1'b1;
          data_last = (dfl_rem == DFL_CNT_W'(1)) || s_axis_tlast;
          if (dfl_rem == DFL_CNT_W'(1)) begin
            state_nxt = s_axis_tlast ? ST_HDR : ST_PAD;
          end else if (s_axis_tlast) begin
            trunc_set = 1'b1;
            state_nxt = ST_HDR;
          end
        end
      end
      ST_PAD, ST_DROP: begin
        if (s_accept && s_axis_tlast) state_nxt = ST_HDR;
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  // State register.
  always_ff @(posedge iclk) begin
    if (ireset) state <= ST_HDR;
    else        state <= state_nxt;
  end

  // Header capture, byte counters and frame tag.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      hdr_cnt   <= '0;
      hdr_buf   <= '0;
      dfl_rem   <= '0;
      frame_tag <= '0;
    end else begin
      if ((state == ST_HDR) && s_accept) begin
        hdr_buf <= {hdr_buf[63:0], s_axis_tdata};
        hdr_cnt <= (hdr_last_byte || s_axis_tlast) ? '0 : hdr_cnt + HDR_CNT_W'(1);
        if (hdr_cnt == '0) frame_tag <= s_axis_tuser;
      end
      if (hdr_ok)         dfl_rem <= hdr_c.dfl[15:3];
      else if (data_load) dfl_rem <= dfl_rem - DFL_CNT_W'(1);
    end
  end

  // Registered outputs: header fields, status pulses, one-deep output slot.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      ohdr_valid    <= 1'b0;
      omatype       <= '0;
      oupl          <= '0;
      odfl          <= '0;
      osync         <= '0;
      osyncd        <= '0;
      odfl_err      <= 1'b0;
      otrunc        <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      ohdr_valid <= hdr_ok;
      odfl_err   <= dfl_bad;
      otrunc     <= trunc_set;
      if (hdr_ok) begin
        omatype <= hdr_c.matype;
        oupl    <= hdr_c.upl;
        odfl    <= hdr_c.dfl;
        osync   <= hdr_c.sync;
        osyncd  <= hdr_c.syncd;
      end
      if (data_load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tlast  <= data_last;
        m_axis_tuser  <= frame_tag;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef DVB_S2X_BBH_CRC_CHECK_EN
  // CRC status outputs.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      ocrc_err  <= 1'b0;
      omode_hem <= 1'b0;
    end else begin
      ocrc_err <= crc_fail;
      if (hdr_ok) omode_hem <= hem_c;
    end
  end
`else
  assign ocrc_err  = 1'b0;
  assign omode_hem = 1'b0;
`endif

endmodule
